// File: rtl/axi4_stream_if.sv
// axi4_stream_if
//   AXI4-Stream bundle shared by the frame-buffer gearboxes.
//
//   Parameters:
//     DATA_W  tdata width in bits; tkeep/tstrb are DATA_W/8 bits wide
//     DEST_W  tdest width
//     ID_W    tid width
//     USER_W  tuser width
//
//   Signals: tvalid, tready, tdata, tkeep, tstrb, tlast, tuser, tdest, tid
//   Modports:
//     master  drives everything except tready
//     slave   drives tready only
interface axi4_stream_if #(
    parameter int DATA_W = 64,
    parameter int DEST_W = 4,
    parameter int ID_W   = 4,
    parameter int USER_W = 1
);
    localparam int KEEP_W = DATA_W / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tlast;
    logic [USER_W-1:0] tuser;
    logic [DEST_W-1:0] tdest;
    logic [ID_W-1:0]   tid;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
        output tready
    );
endinterface

// File: rtl/axi4_stream_64b_16b_gbx.sv
// axi4_stream_64b_16b_gbx
//   Read-side gearbox of the frame buffer: unpacks each 64-bit AXI4-Stream
//   beat into up to four 16-bit words, lane 0 (tdata[15:0]) first, at one
//   word per clock. A last beat is trimmed after its highest populated lane;
//   a last beat with no kept bytes still produces one null word so tlast is
//   never lost. tuser marks only the first word of a packet.
//
//   Ports:
//     clk_i  in      clock
//     rst_i  in      asynchronous, active-high reset
//     pkt_i  slave   64-bit stream in  (tkeep/tstrb 8 bits)
//     pkt_o  master  16-bit stream out (tkeep/tstrb 2 bits), fully registered
module axi4_stream_64b_16b_gbx (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  pkt_i,
    axi4_stream_if.master pkt_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t      state_p1;
    logic [1:0]  lane_cnt;       // lane currently presented on pkt_o
    logic [1:0]  last_lane;      // final lane to emit from the held beat
    logic        tfirst;         // next accepted beat starts a packet

    logic [63:0] beat_tdata_p0;
    logic [7:0]  beat_tkeep_p0;
    logic [7:0]  beat_tstrb_p0;
    logic        beat_tlast_p0;

    logic        rx;
    logic        tx;
    logic        lane_done;
    logic [1:0]  next_lane;
    logic [1:0]  load_last_lane;

    // Non-last beats always emit all four lanes; a last beat stops at its
    // highest lane with any kept byte (lane 0 when nothing is kept).
    function automatic logic [1:0] calc_last_lane(input logic [7:0] keep,
                                                  input logic       last);
        logic [1:0] idx;
        idx = 2'd0;
        if (!last) begin
            idx = 2'd3;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (keep[2*i +: 2] != 2'b00) begin
                    idx = 2'(i);
                end
            end
        end
        return idx;
    endfunction

    assign lane_done      = (lane_cnt == last_lane);
    assign next_lane      = lane_cnt + 2'd1;
    assign load_last_lane = calc_last_lane(pkt_i.tkeep, pkt_i.tlast);

    // A new beat is taken when nothing is held, or when the last word of the
    // held beat leaves in this very cycle (back-to-back, no bubble).
    assign pkt_i.tready = (state_p1 == EMPTY) || (pkt_o.tready && lane_done);
    assign pkt_o.tvalid = (state_p1 == SEND);

    assign rx = pkt_i.tvalid && pkt_i.tready;
    assign tx = pkt_o.tvalid && pkt_o.tready;

    // Stage p0: held 64-bit beat; only lanes 1..3 are ever read back from it,
    // lane 0 goes straight from pkt_i to the output register.
    always_ff @(posedge clk_i) begin
        if (rx) begin
            beat_tdata_p0 <= pkt_i.tdata;
            beat_tkeep_p0 <= pkt_i.tkeep;
            beat_tstrb_p0 <= pkt_i.tstrb;
            beat_tlast_p0 <= pkt_i.tlast;
        end
    end

    // Stage p1: lane sequencer and registered output word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_p1    <= EMPTY;
            lane_cnt    <= 2'd0;
            last_lane   <= 2'd0;
            tfirst      <= 1'b1;
            pkt_o.tdata <= '0;
            pkt_o.tkeep <= '0;
            pkt_o.tstrb <= '0;
            pkt_o.tlast <= 1'b0;
            pkt_o.tuser <= '0;
            pkt_o.tdest <= '0;
            pkt_o.tid   <= '0;
        end else if (rx) begin
            state_p1    <= SEND;
            lane_cnt    <= 2'd0;
            last_lane   <= load_last_lane;
            tfirst      <= pkt_i.tlast;
            pkt_o.tdata <= pkt_i.tdata[15:0];
            pkt_o.tkeep <= pkt_i.tkeep[1:0];
            pkt_o.tstrb <= pkt_i.tstrb[1:0];
            pkt_o.tlast <= pkt_i.tlast && (load_last_lane == 2'd0);
            pkt_o.tuser <= tfirst ? pkt_i.tuser : '0;
            pkt_o.tdest <= pkt_i.tdest;
            pkt_o.tid   <= pkt_i.tid;
        end else if (tx) begin
            if (!lane_done) begin
                lane_cnt    <= next_lane;
                pkt_o.tdata <= beat_tdata_p0[{next_lane, 4'b0000} +: 16];
                pkt_o.tkeep <= beat_tkeep_p0[{next_lane, 1'b0} +: 2];
                pkt_o.tstrb <= beat_tstrb_p0[{next_lane, 1'b0} +: 2];
                pkt_o.tlast <= beat_tlast_p0 && (next_lane == last_lane);
                pkt_o.tuser <= '0;
            end else begin
                state_p1 <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_axi4_stream_64b_16b_gbx.sv
module tb_axi4_stream_64b_16b_gbx;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    axi4_stream_if #(.DATA_W(64)) in_if ();
    axi4_stream_if #(.DATA_W(16)) out_if ();

    axi4_stream_64b_16b_gbx dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .pkt_i (in_if),
        .pkt_o (out_if)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  k;
        logic [1:0]  s;
        logic        l;
        logic        u;
        logic [3:0]  dest;
        logic [3:0]  id;
    } word_t;

    int    vec_cnt   = 0;
    int    err_cnt   = 0;
    int    stall_err = 0;
    bit    rand_ready = 1'b0;
    bit    tfirst_m  = 1'b1;
    word_t exp_q[$];
    word_t obs_q[$];
    word_t cur_w, prev_w;
    bit    stalled = 1'b0;

    // Reference: words a 64-bit beat must turn into.
    task automatic model_beat(input logic [63:0] d, input logic [7:0] k,
                              input logic [7:0] s, input logic l, input logic u,
                              input logic [3:0] dst, input logic [3:0] i_d);
        int    hb;
        int    n;
        word_t w;
        hb = -1;
        for (int b = 0; b < 8; b++) if (k[b]) hb = b;
        if (!l)          n = 4;
        else if (hb < 0) n = 1;
        else             n = hb / 2 + 1;
        for (int j = 0; j < n; j++) begin
            w.d    = d[16*j +: 16];
            w.k    = k[2*j +: 2];
            w.s    = s[2*j +: 2];
            w.l    = l && (j == n - 1);
            w.u    = (j == 0) ? (u & tfirst_m) : 1'b0;
            w.dest = dst;
            w.id   = i_d;
            exp_q.push_back(w);
        end
        tfirst_m = l;
    endtask

    // Monitor: records accepted beats into the model, emitted words, and
    // any change of the output while it is stalled.
    always @(negedge clk_i) begin
        cur_w = {out_if.tdata, out_if.tkeep, out_if.tstrb, out_if.tlast,
                 out_if.tuser, out_if.tdest, out_if.tid};
        if (rst_i) begin
            tfirst_m = 1'b1;
            stalled  = 1'b0;
        end else begin
            if (stalled && (out_if.tvalid !== 1'b1 || cur_w !== prev_w)) stall_err++;
            stalled = out_if.tvalid && !out_if.tready;
            prev_w  = cur_w;
            if (out_if.tvalid && out_if.tready) obs_q.push_back(cur_w);
            if (in_if.tvalid && in_if.tready)
                model_beat(in_if.tdata, in_if.tkeep, in_if.tstrb, in_if.tlast,
                           in_if.tuser, in_if.tdest, in_if.tid);
        end
    end

    // Sink: always ready, or 50% random ready.
    always @(posedge clk_i) begin
        #1;
        out_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                             input logic l, input logic u, output bit to);
        int n;
        n  = 0;
        to = 1'b0;
        in_if.tvalid = 1'b1;
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tstrb  = 8'($urandom);
        in_if.tlast  = l;
        in_if.tuser  = u;
        in_if.tdest  = 4'($urandom);
        in_if.tid    = 4'($urandom);
        @(negedge clk_i);
        while (!in_if.tready) begin
            n++;
            if (n > 200) begin
                to = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        in_if.tvalid = 1'b0;
    endtask

    task automatic drain(output bit to);
        int n;
        n  = 0;
        to = 1'b0;
        @(negedge clk_i);
        while (out_if.tvalid) begin
            n++;
            if (n > 2000) begin
                to = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        @(negedge clk_i);
        vec_cnt++;
        if ({out_if.tvalid, out_if.tdata, out_if.tkeep, out_if.tstrb, out_if.tlast,
             out_if.tuser, out_if.tdest, out_if.tid} !== 30'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got tvalid=%b tdata=%h tlast=%b tuser=%b, required all 0",
                     out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser);
        end
        vec_cnt++;
        if (in_if.tready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_tready: got %b required 1", in_if.tready);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_single_beat;
        bit          to;
        logic [15:0] ed [4];
        ed = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        send_beat(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b1, to);
        vec_cnt++;
        if (to) begin
            err_cnt++;
            $display("FAIL single_accept: beat not accepted within budget");
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            vec_cnt++;
            if ({out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser, in_if.tready} !==
                {1'b1, ed[i], (i == 3), (i == 0), (i == 3)}) begin
                err_cnt++;
                $display("FAIL single_word%0d: got vld=%b data=%h last=%b user=%b rdy=%b required vld=1 data=%h last=%b user=%b rdy=%b",
                         i, out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser, in_if.tready,
                         ed[i], (i == 3), (i == 0), (i == 3));
            end
        end
        @(negedge clk_i);
        vec_cnt++;
        if (out_if.tvalid !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_idle: got tvalid=%b required 0", out_if.tvalid);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_partial;
        bit t0, t1, t2;
        int ob, eb;
        ob = obs_q.size();
        eb = exp_q.size();
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'($urandom), t0);
        send_beat({$urandom, $urandom}, 8'h0F, 1'b1, 1'($urandom), t1);
        drain(t2);
        vec_cnt++;
        if ((obs_q.size() - ob) != 6 || t0 || t1 || t2) begin
            err_cnt++;
            $display("FAIL partial_count: got %0d words (timeout=%b) required 6",
                     obs_q.size() - ob, t0 | t1 | t2);
        end
        for (int i = 0; i < 6 && ob + i < obs_q.size() && eb + i < exp_q.size(); i++) begin
            vec_cnt++;
            if (obs_q[ob+i] !== exp_q[eb+i]) begin
                err_cnt++;
                $display("FAIL partial_word%0d: got %h required %h", i, obs_q[ob+i], exp_q[eb+i]);
            end
        end
    endtask

    task automatic test_null;
        bit t0, t1;
        int ob, eb;
        ob = obs_q.size();
        eb = exp_q.size();
        send_beat({$urandom, $urandom}, 8'h00, 1'b1, 1'b1, t0);
        drain(t1);
        vec_cnt++;
        if ((obs_q.size() - ob) != 1 || t0 || t1) begin
            err_cnt++;
            $display("FAIL null_count: got %0d words required 1", obs_q.size() - ob);
        end else begin
            vec_cnt++;
            if ({obs_q[ob].k, obs_q[ob].l} !== 3'b001) begin
                err_cnt++;
                $display("FAIL null_word: got keep=%b last=%b required keep=00 last=1",
                         obs_q[ob].k, obs_q[ob].l);
            end
            vec_cnt++;
            if (obs_q[ob] !== exp_q[eb]) begin
                err_cnt++;
                $display("FAIL null_model: got %h required %h", obs_q[ob], exp_q[eb]);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit to_any, t;
        int bubbles, rdy, ob, eb, n;
        to_any  = 1'b0;
        bubbles = 0;
        rdy     = 0;
        ob = obs_q.size();
        eb = exp_q.size();
        fork
            begin
                for (int b = 0; b < 8; b++) begin
                    send_beat({$urandom, $urandom}, 8'hFF, (b == 7), 1'($urandom), t);
                    to_any |= t;
                end
            end
            begin
                n = 0;
                @(negedge clk_i);
                while (!out_if.tvalid && n < 50) begin
                    n++;
                    @(negedge clk_i);
                end
                for (int c = 0; c < 32; c++) begin
                    if (c > 0) @(negedge clk_i);
                    if (!out_if.tvalid) bubbles++;
                    if (in_if.tready) rdy++;
                end
            end
        join
        drain(t);
        to_any |= t;
        vec_cnt++;
        if (bubbles != 0 || to_any) begin
            err_cnt++;
            $display("FAIL b2b_bubbles: got %0d idle clks (timeout=%b) required 0", bubbles, to_any);
        end
        vec_cnt++;
        if (rdy != 8) begin
            err_cnt++;
            $display("FAIL b2b_tready: got tready high %0d of 32 clks required 8", rdy);
        end
        vec_cnt++;
        if ((obs_q.size() - ob) != 32) begin
            err_cnt++;
            $display("FAIL b2b_count: got %0d words required 32", obs_q.size() - ob);
        end
        for (int i = 0; i < 32 && ob + i < obs_q.size() && eb + i < exp_q.size(); i++) begin
            vec_cnt++;
            if (obs_q[ob+i] !== exp_q[eb+i]) begin
                err_cnt++;
                $display("FAIL b2b_word%0d: got %h required %h", i, obs_q[ob+i], exp_q[eb+i]);
            end
        end
    endtask

    task automatic test_random;
        bit to_any, t;
        int ob, eb, nbeats, shown;
        to_any = 1'b0;
        shown  = 0;
        ob = obs_q.size();
        eb = exp_q.size();
        rand_ready = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            nbeats = $urandom_range(1, 3);
            for (int b = 0; b < nbeats; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk_i);
                    #1;
                end
                send_beat({$urandom, $urandom}, 8'($urandom), (b == nbeats - 1),
                          1'($urandom), t);
                to_any |= t;
            end
        end
        drain(t);
        to_any |= t;
        rand_ready = 1'b0;
        vec_cnt++;
        if ((obs_q.size() - ob) != (exp_q.size() - eb) || to_any) begin
            err_cnt++;
            $display("FAIL random_count: got %0d words (timeout=%b) required %0d",
                     obs_q.size() - ob, to_any, exp_q.size() - eb);
        end
        for (int i = 0; ob + i < obs_q.size() && eb + i < exp_q.size(); i++) begin
            vec_cnt++;
            if (obs_q[ob+i] !== exp_q[eb+i]) begin
                err_cnt++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_word%0d: got %h required %h", i, obs_q[ob+i], exp_q[eb+i]);
                end
            end
        end
        vec_cnt++;
        if (stall_err != 0) begin
            err_cnt++;
            $display("FAIL stall_stable: got %0d changes while stalled required 0", stall_err);
        end
    endtask

    task automatic test_reset_mid;
        bit          t0, t1, t2;
        int          ob, eb;
        logic [63:0] d;
        d = {$urandom, $urandom};
        send_beat(d, 8'hFF, 1'b0, 1'b1, t0);
        @(negedge clk_i);
        @(negedge clk_i);
        vec_cnt++;
        if (out_if.tvalid !== 1'b1 || out_if.tdata !== d[31:16]) begin
            err_cnt++;
            $display("FAIL rstmid_word2: got vld=%b data=%h required vld=1 data=%h",
                     out_if.tvalid, out_if.tdata, d[31:16]);
        end
        #1;
        rst_i = 1'b1;
        #1;
        vec_cnt++;
        if (out_if.tvalid !== 1'b0 || in_if.tready !== 1'b1) begin
            err_cnt++;
            $display("FAIL rstmid_drop: got tvalid=%b tready=%b required tvalid=0 tready=1",
                     out_if.tvalid, in_if.tready);
        end
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        ob = obs_q.size();
        eb = exp_q.size();
        d  = {$urandom, $urandom};
        send_beat(d, 8'hFF, 1'b1, 1'b1, t1);
        drain(t2);
        vec_cnt++;
        if ((obs_q.size() - ob) != 4 || t0 || t1 || t2) begin
            err_cnt++;
            $display("FAIL rstmid_count: got %0d words required 4", obs_q.size() - ob);
        end else begin
            vec_cnt++;
            if ({obs_q[ob].d, obs_q[ob].u} !== {d[15:0], 1'b1}) begin
                err_cnt++;
                $display("FAIL rstmid_first: got data=%h user=%b required data=%h user=1",
                         obs_q[ob].d, obs_q[ob].u, d[15:0]);
            end
            for (int i = 0; i < 4; i++) begin
                vec_cnt++;
                if (obs_q[ob+i] !== exp_q[eb+i]) begin
                    err_cnt++;
                    $display("FAIL rstmid_word%0d: got %h required %h", i, obs_q[ob+i], exp_q[eb+i]);
                end
            end
        end
    endtask

    initial begin
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tkeep  = '0;
        in_if.tstrb  = '0;
        in_if.tlast  = 1'b0;
        in_if.tuser  = '0;
        in_if.tdest  = '0;
        in_if.tid    = '0;
        test_reset;
        test_single_beat;
        test_partial;
        test_null;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
